// File: rtl/pc_gen.sv
// pc_gen: fetch-stage PC register and next-PC select, optional RAS via PC_GEN_RAS_EN
module pc_gen #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         StallF,
  input  logic [1:0]                   PCSrc,
  input  logic [XLEN-1:0]              TargetAddr,
  input  logic [XLEN-1:0]              PCNextE,
  input  logic [XLEN-1:0]              TrapVector,
  input  logic                         CompressedF,
  input  logic                         RasPushF,
  input  logic                         RasPopF,
  output logic [XLEN-1:0]              PCF,
  output logic [XLEN-1:0]              PCNextF,
  output logic                         PCValidF,
  output logic                         MisalignF,
  output logic [$clog2(RAS_DEPTH):0]   RasCount
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  logic [XLEN-1:0] r_pc;
  logic            r_valid;
  logic            r_mis;
  logic            w_adv;
  logic [XLEN-1:0] w_tgt;
  logic [XLEN-1:0] w_sel;
  assign w_adv    = r_valid & ~StallF;
  assign PCF      = r_pc;
  assign PCValidF = r_valid;
  assign MisalignF = r_mis;
  assign PCNextF  = r_pc + (CompressedF ? XLEN'(2) : XLEN'(4));
`ifdef PC_GEN_RAS_EN
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [XLEN-1:0] r_stack [RAS_DEPTH];
  logic [PW-1:0]   r_ptr;
  logic [CW-1:0]   r_cnt;
  logic            w_pop;
  logic [PW-1:0]   w_wr_idx;
  assign w_pop    = RasPopF && PCSrc == 2'b01 && r_cnt != '0;
  assign w_tgt    = w_pop ? r_stack[r_ptr] : TargetAddr;
  assign w_wr_idx = w_pop ? r_ptr : r_ptr + 1'b1;
  assign RasCount = r_cnt;
  // Top pointer and occupancy; a push+pop pair replaces the top in place
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_adv) begin
      if (RasPushF && !w_pop) begin
        r_ptr <= r_ptr + 1'b1;
        r_cnt <= (r_cnt == FULL) ? r_cnt : r_cnt + 1'b1;
      end else if (w_pop && !RasPushF) begin
        r_ptr <= r_ptr - 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
  // Stack storage needs no reset: entries are only read while counted valid
  always_ff @(posedge clk) begin
    if (w_adv && RasPushF) r_stack[w_wr_idx] <= PCNextF;
  end
`else
  logic w_unused;
  assign w_unused = ^{RasPushF, RasPopF};
  assign w_tgt    = TargetAddr;
  assign RasCount = '0;
`endif
  // Next-PC source select
  always_comb begin
    w_sel = PCSrc == 2'b00 ? PCNextF :
            PCSrc == 2'b01 ? w_tgt :
            PCSrc == 2'b10 ? PCNextE : TrapVector;
  end
  // PC register; the first edge after reset only raises valid so RESET_VECTOR is fetched
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc    <= RESET_VECTOR;
      r_valid <= 1'b0;
      r_mis   <= 1'b0;
    end else begin
      r_valid <= 1'b1;
      if (w_adv) begin
        r_pc  <= w_sel;
        r_mis <= w_sel[0];
      end
    end
  end
endmodule
